// File: rtl/pu_pkg.sv
// Shared types and defaults for the processing-unit WB SRAM arbiter slice.
package pu_pkg;

    // Buffer type of a requester lane; the numeric value is the lane group index.
    typedef enum logic [1:0] {
        WB_IDX    = 2'd0,
        WB_UNIQUE = 2'd1,
        WB_REP    = 2'd2
    } wb_type_e;

    // Arbiter transaction state.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_READ = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int unsigned PU_NUM_CH = 8;
    localparam int unsigned PU_SRAM_W = 64;

endpackage

// File: rtl/pu_rr_arbiter.sv
// Generic N-input arbiter: round-robin starting at ptr, or fixed priority
// (lowest index wins). Purely combinational; the caller owns the pointer.
module pu_rr_arbiter import pu_pkg::*; #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          fixed_mode,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] start_s;
    logic [IW:0]   cand_s;

    // Scan once around the ring from the start point and take the first pending request.
    always_comb begin
        grant       = {N{1'b0}};
        grant_idx   = {IW{1'b0}};
        grant_valid = 1'b0;
        cand_s      = {(IW+1){1'b0}};
        if (fixed_mode) begin
            start_s = {IW{1'b0}};
        end else begin
            start_s = ptr;
        end
        for (int i = 0; i < int'(N); i++) begin
            cand_s = {1'b0, start_s} + (IW+1)'(i);
            if (cand_s >= (IW+1)'(N)) begin
                cand_s = cand_s - (IW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_valid && req[cand_s[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_s[IW-1:0];
            end else begin
                grant_valid = grant_valid;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = {N{1'b0}};
        end
    end

endmodule

// File: rtl/pu_wb_sram_arbiter.sv
// Arbitrates idx/unique/rep word reads of all input-channel lanes onto a
// single WB SRAM read port. One transaction in flight; the returned word is
// broadcast on word_out and the winner gets a one-cycle ready pulse.
module pu_wb_sram_arbiter import pu_pkg::*; #(
    parameter  int unsigned NUM_CH = PU_NUM_CH,
    parameter  int unsigned SRAM_W = PU_SRAM_W,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arb_mode,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [31:0]             idx_base,
    input  logic [31:0]             unique_base,
    input  logic [31:0]             rep_base,
    input  logic [31:0]             ch_stride,
    input  logic [NUM_CH-1:0][31:0] idx_cnt,
    input  logic [NUM_CH-1:0][31:0] unique_cnt,
    input  logic [NUM_CH-1:0][31:0] rep_cnt,
    input  logic [NUM_CH-1:0]       idx_read,
    input  logic [NUM_CH-1:0]       unique_read,
    input  logic [NUM_CH-1:0]       rep_read,
    output logic [NUM_CH-1:0]       idx_ready,
    output logic [NUM_CH-1:0]       unique_ready,
    output logic [NUM_CH-1:0]       rep_ready,
    output logic [SRAM_W-1:0]       word_out,
    output logic                    sram_read,
    output logic [31:0]             sram_address,
    input  logic                    sram_ready,
    input  logic [SRAM_W-1:0]       sram_in,
    output logic                    busy,
    output logic [1:0]              grant_type,
    output logic [CH_W-1:0]         grant_ch
);

    localparam int unsigned NR = 3 * NUM_CH;
    localparam int unsigned RW = $clog2(NR);

    // Flattened requesters: r = type*NUM_CH + ch.
    logic [NR-1:0]     req_s;
    logic [NR-1:0]     win_onehot_s;
    logic [RW-1:0]     win_idx_s;
    logic              win_valid_s;
    wb_type_e          win_type_s;
    logic [CH_W-1:0]   win_ch_s;
    logic [31:0]       base_sel_s;
    logic [31:0]       cnt_sel_s;
    logic [31:0]       win_addr_s;
    logic [RW-1:0]     ptr_next_s;

    arb_state_e        state_r, state_nx_s;
    logic [RW-1:0]     ptr_r, ptr_nx_s;
    logic [NR-1:0]     gnt_onehot_r, gnt_onehot_nx_s;
    logic [NR-1:0]     rdy_r, rdy_nx_s;
    logic              sram_read_r, sram_read_nx_s;
    logic [31:0]       sram_address_r, sram_address_nx_s;
    logic [SRAM_W-1:0] word_out_r, word_out_nx_s;
    logic              busy_r, busy_nx_s;
    wb_type_e          grant_type_r, grant_type_nx_s;
    logic [CH_W-1:0]   grant_ch_r, grant_ch_nx_s;

    assign req_s = {rep_read & ch_mask, unique_read & ch_mask, idx_read & ch_mask};

    pu_rr_arbiter #(
        .N  (NR),
        .IW (RW)
    ) u_arb (
        .req         (req_s),
        .ptr         (ptr_r),
        .fixed_mode  (arb_mode),
        .grant       (win_onehot_s),
        .grant_idx   (win_idx_s),
        .grant_valid (win_valid_s)
    );

    // Split the winning flat index back into buffer type and lane.
    always_comb begin
        if (win_idx_s < RW'(NUM_CH)) begin
            win_type_s = WB_IDX;
            win_ch_s   = CH_W'(win_idx_s);
        end else if (win_idx_s < RW'(2 * NUM_CH)) begin
            win_type_s = WB_UNIQUE;
            win_ch_s   = CH_W'(win_idx_s - RW'(NUM_CH));
        end else begin
            win_type_s = WB_REP;
            win_ch_s   = CH_W'(win_idx_s - RW'(2 * NUM_CH));
        end
    end

    // Word address of the winner: region base + lane offset + lane counter, wrapping mod 2^32.
    always_comb begin
        case (win_type_s)
            WB_IDX: begin
                base_sel_s = idx_base;
                cnt_sel_s  = idx_cnt[win_ch_s];
            end
            WB_UNIQUE: begin
                base_sel_s = unique_base;
                cnt_sel_s  = unique_cnt[win_ch_s];
            end
            WB_REP: begin
                base_sel_s = rep_base;
                cnt_sel_s  = rep_cnt[win_ch_s];
            end
            default: begin
                base_sel_s = 32'h0000_0000;
                cnt_sel_s  = 32'h0000_0000;
            end
        endcase
        win_addr_s = base_sel_s + ({{(32-CH_W){1'b0}}, win_ch_s} * ch_stride) + cnt_sel_s;
    end

    assign ptr_next_s = (win_idx_s == RW'(NR - 1)) ? {RW{1'b0}} : (win_idx_s + RW'(1));

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nx_s        = state_r;
        ptr_nx_s          = ptr_r;
        gnt_onehot_nx_s   = gnt_onehot_r;
        rdy_nx_s          = {NR{1'b0}};
        sram_read_nx_s    = sram_read_r;
        sram_address_nx_s = sram_address_r;
        word_out_nx_s     = word_out_r;
        busy_nx_s         = busy_r;
        grant_type_nx_s   = grant_type_r;
        grant_ch_nx_s     = grant_ch_r;
        case (state_r)
            ARB_IDLE: begin
                if (win_valid_s) begin
                    state_nx_s        = ARB_READ;
                    gnt_onehot_nx_s   = win_onehot_s;
                    grant_type_nx_s   = win_type_s;
                    grant_ch_nx_s     = win_ch_s;
                    sram_address_nx_s = win_addr_s;
                    sram_read_nx_s    = 1'b1;
                    busy_nx_s         = 1'b1;
                    if (arb_mode) begin
                        ptr_nx_s = ptr_r;
                    end else begin
                        ptr_nx_s = ptr_next_s;
                    end
                end else begin
                    state_nx_s = ARB_IDLE;
                end
            end
            ARB_READ: begin
                if (sram_ready) begin
                    state_nx_s     = ARB_DONE;
                    word_out_nx_s  = sram_in;
                    rdy_nx_s       = gnt_onehot_r;
                    sram_read_nx_s = 1'b0;
                end else begin
                    state_nx_s = ARB_READ;
                end
            end
            ARB_DONE: begin
                state_nx_s = ARB_IDLE;
                busy_nx_s  = 1'b0;
            end
            default: begin
                state_nx_s     = ARB_IDLE;
                sram_read_nx_s = 1'b0;
                busy_nx_s      = 1'b0;
            end
        endcase
    end

    // FSM state and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ARB_IDLE;
            ptr_r   <= {RW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
        end
    end

    // Registered outputs and latched grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_onehot_r   <= {NR{1'b0}};
            rdy_r          <= {NR{1'b0}};
            sram_read_r    <= 1'b0;
            sram_address_r <= 32'h0000_0000;
            word_out_r     <= {SRAM_W{1'b0}};
            busy_r         <= 1'b0;
            grant_type_r   <= WB_IDX;
            grant_ch_r     <= {CH_W{1'b0}};
        end else begin
            gnt_onehot_r   <= gnt_onehot_nx_s;
            rdy_r          <= rdy_nx_s;
            sram_read_r    <= sram_read_nx_s;
            sram_address_r <= sram_address_nx_s;
            word_out_r     <= word_out_nx_s;
            busy_r         <= busy_nx_s;
            grant_type_r   <= grant_type_nx_s;
            grant_ch_r     <= grant_ch_nx_s;
        end
    end

    assign idx_ready    = rdy_r[NUM_CH-1:0];
    assign unique_ready = rdy_r[2*NUM_CH-1:NUM_CH];
    assign rep_ready    = rdy_r[3*NUM_CH-1:2*NUM_CH];
    assign word_out     = word_out_r;
    assign sram_read    = sram_read_r;
    assign sram_address = sram_address_r;
    assign busy         = busy_r;
    assign grant_type   = grant_type_r;
    assign grant_ch     = grant_ch_r;

endmodule

// File: tb/tb_pu_wb_sram_arbiter.sv
// Directed self-checking bench for pu_wb_sram_arbiter with four lanes.
module tb_pu_wb_sram_arbiter;

    localparam int NUM_CH = 4;
    localparam int SRAM_W = 64;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    arb_mode;
    logic [NUM_CH-1:0]       ch_mask;
    logic [31:0]             idx_base, unique_base, rep_base, ch_stride;
    logic [NUM_CH-1:0][31:0] idx_cnt, unique_cnt, rep_cnt;
    logic [NUM_CH-1:0]       idx_read, unique_read, rep_read;
    logic [NUM_CH-1:0]       idx_ready, unique_ready, rep_ready;
    logic [SRAM_W-1:0]       word_out;
    logic                    sram_read;
    logic [31:0]             sram_address;
    logic                    sram_ready;
    logic [SRAM_W-1:0]       sram_in;
    logic                    busy;
    logic [1:0]              grant_type;
    logic [1:0]              grant_ch;

    logic [3*NUM_CH-1:0]     rdy_all;
    int n_cmp = 0;
    int n_bad = 0;

    assign rdy_all = {rep_ready, unique_ready, idx_ready};

    pu_wb_sram_arbiter #(.NUM_CH(NUM_CH), .SRAM_W(SRAM_W)) dut (
        .clock(clock), .reset(reset), .arb_mode(arb_mode), .ch_mask(ch_mask),
        .idx_base(idx_base), .unique_base(unique_base), .rep_base(rep_base),
        .ch_stride(ch_stride), .idx_cnt(idx_cnt), .unique_cnt(unique_cnt),
        .rep_cnt(rep_cnt), .idx_read(idx_read), .unique_read(unique_read),
        .rep_read(rep_read), .idx_ready(idx_ready), .unique_ready(unique_ready),
        .rep_ready(rep_ready), .word_out(word_out), .sram_read(sram_read),
        .sram_address(sram_address), .sram_ready(sram_ready), .sram_in(sram_in),
        .busy(busy), .grant_type(grant_type), .grant_ch(grant_ch)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    // Bounded wait for the arbiter to start an SRAM read.
    task automatic wait_read(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sram_read === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: sram_read never rose within 30 cycles, required a grant", tag);
        end
    endtask

    function automatic int granted_r();
        return int'(grant_type) * NUM_CH + int'(grant_ch);
    endfunction

    task automatic test_reset();
        arb_mode = 1'b0; ch_mask = 4'hF;
        idx_base = 0; unique_base = 0; rep_base = 0; ch_stride = 0;
        idx_cnt = '0; unique_cnt = '0; rep_cnt = '0;
        idx_read = 0; unique_read = 0; rep_read = 0;
        sram_ready = 1'b0; sram_in = '0;
        reset = 1'b1;
        step(); step();
        n_cmp++;
        if (sram_read !== 1'b0 || sram_address !== 32'h0 || word_out !== 64'h0 || rdy_all !== 12'h0 ||
            busy !== 1'b0 || grant_type !== 2'd0 || grant_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: rd=%b addr=%h word=%h rdy=%h busy=%b gt=%0d gc=%0d, required all 0",
                     sram_read, sram_address, word_out, rdy_all, busy, grant_type, grant_ch);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || sram_read !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b rd=%b, required 0/0", busy, sram_read);
        end
    endtask

    task automatic test_round_robin();
        int r;
        logic [11:0] exp_rdy;
        sram_ready = 1'b1;
        idx_read = 4'hF; unique_read = 4'hF; rep_read = 4'hF;
        for (int k = 0; k < 13; k++) begin
            wait_read("rr");
            r = granted_r();
            n_cmp++;
            if (r !== (k % 12)) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got r=%0d, required r=%0d", k, r, k % 12);
            end
            step();
            exp_rdy = 12'h001 << (k % 12);
            n_cmp++;
            if (rdy_all !== exp_rdy) begin
                n_bad++;
                $display("FAIL rr_ready[%0d]: got %h, required %h", k, rdy_all, exp_rdy);
            end
            if (k == 12) begin
                idx_read = 0; unique_read = 0; rep_read = 0;
            end
            step();
        end
    endtask

    task automatic test_single();
        idx_base = 32'h100; ch_stride = 32'h40; idx_cnt[2] = 32'd5;
        sram_ready = 1'b1; sram_in = 64'hDEAD_BEEF_0123_4567;
        idx_read = 4'b0100;
        step();
        n_cmp++;
        if (sram_read !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_read: rd=%b busy=%b, required 1/1", sram_read, busy);
        end
        n_cmp++;
        if (sram_address !== 32'h185) begin
            n_bad++;
            $display("FAIL single_addr: got %h, required 00000185", sram_address);
        end
        n_cmp++;
        if (grant_type !== 2'd0 || grant_ch !== 2'd2) begin
            n_bad++;
            $display("FAIL single_grant: gt=%0d gc=%0d, required 0/2", grant_type, grant_ch);
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h004 || word_out !== 64'hDEAD_BEEF_0123_4567 || sram_read !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: rdy=%h word=%h rd=%b, required 004/deadbeef01234567/0",
                     rdy_all, word_out, sram_read);
        end
        idx_read = 0; sram_in = 64'h0;
        step();
        n_cmp++;
        if (rdy_all !== 12'h0 || busy !== 1'b0 || word_out !== 64'hDEAD_BEEF_0123_4567) begin
            n_bad++;
            $display("FAIL single_after: rdy=%h busy=%b word=%h, required 000/0/deadbeef01234567",
                     rdy_all, busy, word_out);
        end
        idx_base = 0; ch_stride = 0; idx_cnt[2] = 0;
    endtask

    task automatic test_fixed_priority();
        arb_mode = 1'b1; sram_ready = 1'b1;
        unique_read = 4'b0001; idx_read = 4'b1000;
        step();
        n_cmp++;
        if (granted_r() !== 3) begin
            n_bad++;
            $display("FAIL fixed_first: got r=%0d, required r=3", granted_r());
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h008) begin
            n_bad++;
            $display("FAIL fixed_first_rdy: got %h, required 008", rdy_all);
        end
        idx_read = 0;
        step(); step();
        n_cmp++;
        if (granted_r() !== 4) begin
            n_bad++;
            $display("FAIL fixed_second: got r=%0d, required r=4", granted_r());
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h010) begin
            n_bad++;
            $display("FAIL fixed_second_rdy: got %h, required 010", rdy_all);
        end
        unique_read = 0;
        step();
        // Pointer was 3 before the fixed grants and must still be 3: r=4 beats r=2.
        arb_mode = 1'b0;
        idx_read = 4'b0100; unique_read = 4'b0001;
        step();
        n_cmp++;
        if (granted_r() !== 4) begin
            n_bad++;
            $display("FAIL fixed_ptr_kept: got r=%0d, required r=4", granted_r());
        end
        step();
        unique_read = 0;
        step(); step();
        n_cmp++;
        if (granted_r() !== 2) begin
            n_bad++;
            $display("FAIL rr_after_fixed: got r=%0d, required r=2", granted_r());
        end
        step();
        idx_read = 0;
        step();
    endtask

    task automatic test_mask();
        bit leaked = 1'b0;
        ch_mask = 4'b1011; rep_base = 32'h2000; ch_stride = 32'h40; rep_cnt[2] = 32'd7;
        sram_ready = 1'b1; rep_read = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sram_read !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
        end
        n_cmp++;
        if (leaked) begin
            n_bad++;
            $display("FAIL mask_blocked: masked request was granted, required no sram_read for 20 cycles");
        end
        ch_mask = 4'hF;
        wait_read("mask");
        n_cmp++;
        if (sram_address !== 32'h2087 || grant_type !== 2'd2 || grant_ch !== 2'd2) begin
            n_bad++;
            $display("FAIL mask_grant: addr=%h gt=%0d gc=%0d, required 00002087/2/2",
                     sram_address, grant_type, grant_ch);
        end
        step();
        n_cmp++;
        if (rep_ready !== 4'b0100 || idx_ready !== 4'b0 || unique_ready !== 4'b0) begin
            n_bad++;
            $display("FAIL mask_ready: rdy=%h, required 400", rdy_all);
        end
        rep_read = 0;
        step();
        rep_base = 0; ch_stride = 0; rep_cnt[2] = 0;
    endtask

    task automatic test_stall_wrap();
        bit stable = 1'b1;
        unique_base = 32'hFFFF_FFF0; unique_cnt[0] = 32'h20; ch_stride = 32'h40;
        sram_ready = 1'b0; unique_read = 4'b0001;
        step();
        n_cmp++;
        if (sram_read !== 1'b1 || sram_address !== 32'h0000_0010) begin
            n_bad++;
            $display("FAIL wrap_addr: rd=%b addr=%h, required 1/00000010", sram_read, sram_address);
        end
        unique_read = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (sram_read !== 1'b1 || sram_address !== 32'h10 || rdy_all !== 12'h0 || busy !== 1'b1)
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL stall_hold: rd=%b addr=%h rdy=%h busy=%b, required 1/00000010/000/1 throughout",
                     sram_read, sram_address, rdy_all, busy);
        end
        sram_ready = 1'b1; sram_in = 64'h0123_4567_89AB_CDEF;
        step();
        n_cmp++;
        if (rdy_all !== 12'h010 || word_out !== 64'h0123_4567_89AB_CDEF) begin
            n_bad++;
            $display("FAIL stall_done: rdy=%h word=%h, required 010/0123456789abcdef", rdy_all, word_out);
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h0 || busy !== 1'b0 || sram_read !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_after: rdy=%h busy=%b rd=%b, required 000/0/0", rdy_all, busy, sram_read);
        end
        unique_base = 0; unique_cnt[0] = 0; ch_stride = 0;
    endtask

    task automatic test_reset_in_read();
        bit stale = 1'b0;
        sram_ready = 1'b0; idx_read = 4'b0010;
        step();
        n_cmp++;
        if (busy !== 1'b1 || sram_read !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: busy=%b rd=%b, required 1/1", busy, sram_read);
        end
        idx_read = 0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (sram_read !== 1'b0 || sram_address !== 32'h0 || word_out !== 64'h0 || rdy_all !== 12'h0 ||
            busy !== 1'b0 || grant_type !== 2'd0 || grant_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_async: rd=%b addr=%h word=%h rdy=%h busy=%b gt=%0d gc=%0d, required all 0",
                     sram_read, sram_address, word_out, rdy_all, busy, grant_type, grant_ch);
        end
        step();
        reset = 1'b0; sram_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rdy_all !== 12'h0 || busy !== 1'b0) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_bad++;
            $display("FAIL rst_stale: activity after reset without request, required none");
        end
        idx_read = 4'b0010; rep_read = 4'b1000;
        step();
        n_cmp++;
        if (granted_r() !== 1) begin
            n_bad++;
            $display("FAIL rst_ptr0: got r=%0d, required r=1", granted_r());
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h002) begin
            n_bad++;
            $display("FAIL rst_rdy1: got %h, required 002", rdy_all);
        end
        idx_read = 0;
        step(); step();
        n_cmp++;
        if (granted_r() !== 11) begin
            n_bad++;
            $display("FAIL rst_next: got r=%0d, required r=11", granted_r());
        end
        step();
        n_cmp++;
        if (rdy_all !== 12'h800) begin
            n_bad++;
            $display("FAIL rst_rdy11: got %h, required 800", rdy_all);
        end
        rep_read = 0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fixed_priority();
        test_mask();
        test_stall_wrap();
        test_reset_in_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pu_wb_sram_arbiter.md
PU_WB_SRAM_ARBITER -- requirements
Module: pu_wb_sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of input-channel lanes, each owning idx, unique and repetition buffers.
REQ-002 SHALL have parameter SRAM_W, default 64: WB SRAM word width.
REQ-003 SHALL have port clock, in, 1: single clock, rising edge.
REQ-004 SHALL have port reset, in, 1: asynchronous, active-high reset.
REQ-005 SHALL have port arb_mode, in, 1: 0 = round-robin, 1 = fixed priority.
REQ-006 SHALL have port ch_mask, in, NUM_CH: 1 = lane eligible.
REQ-007 SHALL have ports idx_base, unique_base, rep_base, in, 32 each: region start addresses.
REQ-008 SHALL have port ch_stride, in, 32: per-lane word offset inside each region.
REQ-009 SHALL have ports idx_cnt, unique_cnt, rep_cnt, in, NUM_CH x 32: per-lane word counters.
REQ-010 SHALL have ports idx_read, unique_read, rep_read, in, NUM_CH: word requests.
REQ-011 SHALL have ports idx_ready, unique_ready, rep_ready, out, NUM_CH: one-cycle completion pulses.
REQ-012 SHALL have port word_out, out, SRAM_W: returned word, broadcast to all lanes.
REQ-013 SHALL have port sram_read, out, 1; sram_address, out, 32; sram_ready, in, 1; sram_in, in, SRAM_W.
REQ-014 SHALL have ports busy, out, 1; grant_type, out, 2; grant_ch, out, clog2(NUM_CH).

Function
REQ-015 Requesters SHALL be flattened as r = type*NUM_CH + ch, with type idx=0, unique=1, rep=2; 3*NUM_CH requesters total.
REQ-016 Requester r SHALL be pending when its read bit is 1 and ch_mask[ch] is 1; masked requests are never granted.
REQ-017 The FSM SHALL have states IDLE, READ and DONE.
REQ-018 IDLE: when any request is pending, SHALL latch the winner, grant_type, grant_ch and the address, then go to READ; otherwise stay in IDLE.
REQ-019 Address SHALL be base[type] + ch*ch_stride + cnt[type][ch], computed modulo 2^32 (wraps, no error).
REQ-020 READ: sram_read=1 with sram_address held constant; the cycle sram_ready=1, SHALL register sram_in into word_out and go to DONE.
REQ-021 DONE: SHALL pulse the granted ready bit for exactly one cycle, with word_out valid, then go to IDLE.
REQ-022 word_out SHALL hold until the next DONE.
REQ-023 Minimum latency: read sampled in IDLE at edge 0, sram_read at cycle 1, ready pulse at cycle 2 when sram_ready=1 in cycle 1.
REQ-024 A requester SHALL deassert read in the cycle after its ready pulse; the arbiter does not re-sample requests during DONE.
REQ-025 Round-robin: the search SHALL start at ptr; after a grant to r, ptr = (r+1) mod 3*NUM_CH.
REQ-026 Fixed priority: the lowest pending r SHALL win, and ptr SHALL be left unchanged.
REQ-027 Changes to arb_mode, ch_mask or base while in READ or DONE SHALL NOT affect the transaction in flight.
REQ-028 A requester dropping read during READ SHALL NOT abort the transaction; its ready still pulses.
REQ-029 busy SHALL be 1 in READ and DONE, and 0 in IDLE.
REQ-030 Only one SRAM transaction SHALL be outstanding at a time.

Reset
REQ-031 On reset, state=IDLE and ptr=0, asynchronously, including mid-READ; any transaction in flight is aborted with no ready pulse.
REQ-032 On reset, all outputs SHALL be 0: sram_read, sram_address, word_out, all ready bits, busy, grant_type and grant_ch.

Structure
REQ-033 Shared package pu_pkg SHALL hold the wb_type_e enum (WB_IDX, WB_UNIQUE, WB_REP), the arbiter state enum and the default NUM_CH/SRAM_W constants.
REQ-034 Requester selection SHALL live in sub-module pu_rr_arbiter: a generic N-input arbiter with ptr input, fixed/rr mode, one-hot grant and index output.

Verification
REQ-035 Single request: NUM_CH=4, idx_base=0x100, ch_stride=0x40, idx_cnt[2]=5, idx_read[2]=1, sram_ready tied 1 -> sram_address=0x185 at cycle 1; idx_ready[2] pulses at cycle 2 with word_out = sram_in.
REQ-036 Round-robin: mode 0, all 12 reads held high -> grant order r=0,1,...,11,0; each lane served once per 12 grants.
REQ-037 Fixed priority: mode 1, unique_read[0] and idx_read[3] high together -> idx ch3 (r=3) granted before unique ch0 (r=4).
REQ-038 Mask: ch_mask=4'b1011, only rep_read[2]=1 -> sram_read stays 0 for 20 cycles; set ch_mask[2]=1 -> grant follows, address rep_base+2*ch_stride+rep_cnt[2].
REQ-039 Stall and wrap: sram_ready low for 7 cycles, unique_base=0xFFFFFFF0, unique_cnt=0x20 -> address 0x00000010 held stable; ready pulses 1 cycle after sram_ready rises.
REQ-040 Reset in READ -> all outputs 0 immediately; after release, a fresh request restarts at ptr=0 with no stale ready pulse.
